// File: rtl/product_accumulator.sv
// Accumulates signed products from an upstream Booth multiplier into saturating frame sums.
// A frame ends after FRAME_LEN products or on flush, and is held until downstream takes it.
module product_accumulator #(
    parameter int WIDTH     = 6,
    parameter int ACC_WIDTH = 16,
    parameter int FRAME_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   product,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sat,
    output logic [7:0]           terms
);

    typedef enum logic {ACC, HOLD} state_t;

    localparam logic [7:0]           LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [ACC_WIDTH-1:0] SUM_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SUM_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t               state;
    state_t               next_state;
    logic [ACC_WIDTH-1:0] acc;
    logic [7:0]           count;
    logic                 sat_r;
    logic                 accept;
    logic [ACC_WIDTH:0]   wide_sum;
    logic [ACC_WIDTH-1:0] clamped;
    logic                 overflow;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign sum       = acc;
    assign sat       = sat_r;
    assign terms     = count;

    // One guard bit catches overflow: the top two bits disagree exactly when the sum left range.
    always_comb begin
        wide_sum = {{(ACC_WIDTH + 1 - 2*WIDTH){product[2*WIDTH-1]}}, product}
                 + {acc[ACC_WIDTH-1], acc};
        overflow = (wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1]);
        clamped  = wide_sum[ACC_WIDTH-1:0];
        if (overflow) begin
            clamped = wide_sum[ACC_WIDTH] ? SUM_MIN : SUM_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= next_state;
        end
    end

    // An accept on the flush cycle still counts, so flush with an empty frame but a live accept ends it.
    always_comb begin
        next_state = state;
        case (state)
            ACC: begin
                if ((accept && count == LAST_IDX) || (flush && (count != 8'd0 || accept))) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state = ACC;
                end
            end
            default: next_state = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            sat_r <= 1'b0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                acc   <= '0;
                count <= '0;
                sat_r <= 1'b0;
            end
        end else if (accept) begin
            acc   <= clamped;
            count <= count + 8'd1;
            sat_r <= sat_r | overflow;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Drives two accumulators (16-bit and 12-bit sums) with identical traffic and
// compares both against a frame-level reference model built from product lists.
module tb_product_accumulator;

    localparam int FRAME_LEN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [11:0] product;
    logic        flush;
    logic        out_ready;

    logic        in_ready16, out_valid16, sat16;
    logic [15:0] sum16;
    logic [7:0]  terms16;
    logic        in_ready12, out_valid12, sat12;
    logic [11:0] sum12;
    logic [7:0]  terms12;

    int checks   = 0;
    int failures = 0;

    bit m_hold;
    int frame_q[$];

    always #5 clk = ~clk;

    product_accumulator dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .product(product), .flush(flush), .out_valid(out_valid16),
        .out_ready(out_ready), .sum(sum16), .sat(sat16), .terms(terms16)
    );

    product_accumulator #(.WIDTH(6), .ACC_WIDTH(12), .FRAME_LEN(FRAME_LEN)) dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
        .product(product), .flush(flush), .out_valid(out_valid12),
        .out_ready(out_ready), .sum(sum12), .sat(sat12), .terms(terms12)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Running sum with clamping to the signed range of accw bits after every product.
    function automatic longint frameSum(input int accw, output bit sat_o);
        longint hi = (longint'(1) << (accw - 1)) - 1;
        longint lo = -(longint'(1) << (accw - 1));
        longint s  = 0;
        sat_o = 1'b0;
        foreach (frame_q[i]) begin
            s += frame_q[i];
            if (s > hi) begin
                s = hi;
                sat_o = 1'b1;
            end else if (s < lo) begin
                s = lo;
                sat_o = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic modelStep();
        if (!m_hold) begin
            if (in_valid) frame_q.push_back(int'($signed(product)));
            if (frame_q.size() == FRAME_LEN || (flush && frame_q.size() > 0)) m_hold = 1'b1;
        end else if (out_ready) begin
            m_hold = 1'b0;
            frame_q.delete();
        end
    endtask

    task automatic checkOutput(input string tag);
        bit     s16, s12;
        longint e16, e12;
        check({tag, "_in_ready16"},  longint'(in_ready16),  longint'(!m_hold));
        check({tag, "_in_ready12"},  longint'(in_ready12),  longint'(!m_hold));
        check({tag, "_out_valid16"}, longint'(out_valid16), longint'(m_hold));
        check({tag, "_out_valid12"}, longint'(out_valid12), longint'(m_hold));
        if (m_hold) begin
            e16 = frameSum(16, s16);
            e12 = frameSum(12, s12);
            check({tag, "_sum16"},   longint'($signed(sum16)), e16);
            check({tag, "_sum12"},   longint'($signed(sum12)), e12);
            check({tag, "_sat16"},   longint'(sat16), longint'(s16));
            check({tag, "_sat12"},   longint'(sat12), longint'(s12));
            check({tag, "_terms16"}, longint'(terms16), longint'(frame_q.size()));
            check({tag, "_terms12"}, longint'(terms12), longint'(frame_q.size()));
        end
    endtask

    task automatic applyStimulus(input string tag, input bit v, input int p, input bit f, input bit r);
        in_valid  = v;
        product   = 12'(p);
        flush     = f;
        out_ready = r;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    // Reset is asserted between edges so the asynchronous clear is observed before any clock.
    task automatic resetCheck(input string tag);
        rst = 1'b1;
        #1;
        m_hold = 1'b0;
        frame_q.delete();
        check({tag, "_sum16"},      longint'(sum16), 0);
        check({tag, "_sum12"},      longint'(sum12), 0);
        check({tag, "_sat16"},      longint'(sat16), 0);
        check({tag, "_terms16"},    longint'(terms16), 0);
        check({tag, "_in_ready16"}, longint'(in_ready16), 1);
        check({tag, "_out_valid16"},longint'(out_valid16), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        in_valid  = 1'b0;
        product   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        m_hold    = 1'b0;
        resetCheck("reset");

        applyStimulus("basic", 1, 10, 0, 1);
        applyStimulus("basic", 1, -3, 0, 1);
        applyStimulus("basic", 1, 25, 0, 1);
        applyStimulus("basic", 1, -32, 0, 1);
        check("basic_sum_const",   longint'($signed(sum16)), 0);
        check("basic_terms_const", longint'(terms16), 4);
        applyStimulus("basic_release", 0, 0, 0, 1);

        for (int i = 1; i <= 4; i++) applyStimulus("bp_fill", 1, i, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus("bp_hold", 1, 99, 1, 0);
        check("bp_sum_const", longint'($signed(sum16)), 10);
        applyStimulus("bp_release", 1, 99, 0, 1);
        applyStimulus("bp_idle", 0, 0, 0, 1);

        applyStimulus("flush", 1, 7, 0, 1);
        applyStimulus("flush", 1, 8, 0, 1);
        applyStimulus("flush", 0, 0, 1, 1);
        check("flush_sum_const",   longint'($signed(sum16)), 15);
        check("flush_terms_const", longint'(terms16), 2);
        applyStimulus("flush_release", 0, 0, 0, 1);
        applyStimulus("flush_empty", 0, 0, 1, 1);
        check("flush_empty_valid", longint'(out_valid16), 0);

        applyStimulus("flush_acc", 1, 100, 0, 1);
        applyStimulus("flush_acc", 1, 200, 1, 1);
        check("flush_acc_sum_const", longint'($signed(sum16)), 300);
        applyStimulus("flush_acc_release", 0, 0, 0, 1);

        for (int i = 0; i < 4; i++) applyStimulus("sat_pos", 1, 1024, 0, 1);
        check("sat_pos_sum_const", longint'($signed(sum12)), 2047);
        check("sat_pos_sat_const", longint'(sat12), 1);
        applyStimulus("sat_pos_release", 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus("sat_neg", 1, -1024, 0, 1);
        check("sat_neg_sum_const", longint'($signed(sum12)), -2048);
        applyStimulus("sat_neg_release", 0, 0, 0, 1);
        applyStimulus("sat_clear", 1, 1, 0, 1);
        applyStimulus("sat_clear", 1, 1, 1, 1);
        check("sat_clear_sat_const", longint'(sat12), 0);
        applyStimulus("sat_clear_release", 0, 0, 0, 1);

        for (int i = 0; i < 3; i++) applyStimulus("mid_reset", 1, 5, 0, 1);
        resetCheck("mid_reset");
        for (int i = 0; i < 4; i++) applyStimulus("post_reset", 1, 1, 0, 1);
        check("post_reset_sum_const",   longint'($signed(sum16)), 4);
        check("post_reset_terms_const", longint'(terms16), 4);
        applyStimulus("post_reset_release", 0, 0, 0, 1);

        for (int i = 0; i < 300; i++) begin
            applyStimulus("rnd",
                          $urandom_range(0, 3) != 0,
                          int'($urandom_range(0, 4095)),
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 6: operand width of the upstream Booth multiplier; product width is 2*WIDTH.
REQ-002 SHALL have parameter ACC_WIDTH, default 16: accumulator/sum width, with ACC_WIDTH >= 2*WIDTH.
REQ-003 SHALL have parameter FRAME_LEN, default 4: products per frame, range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: product offered.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a product this cycle.
REQ-008 SHALL have port product, input, 2*WIDTH bits: two's-complement product from the upstream multiplier.
REQ-009 SHALL have port flush, input, 1 bit: end the current frame early.
REQ-010 SHALL have port out_valid, output, 1 bit: frame result held.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream takes the result.
REQ-012 SHALL have port sum, output, ACC_WIDTH bits: signed frame sum.
REQ-013 SHALL have port sat, output, 1 bit: saturation occurred in this frame.
REQ-014 SHALL have port terms, output, 8 bits: number of products in the emitted frame.

Function
REQ-015 SHALL use a two-state FSM, ACC and HOLD; in_ready = (state==ACC); out_valid = (state==HOLD).
REQ-016 SHALL accept a product when in_valid && in_ready, i.e. on the handshake only.
REQ-017 SHALL form each new sum from the sign-extended product plus acc, computed at ACC_WIDTH+1 bits.
REQ-018 SHALL clamp on overflow: positive overflow to 2^(ACC_WIDTH-1)-1, negative to -2^(ACC_WIDTH-1); either sets the sticky sat flag for the frame.
REQ-019 SHALL increment the term count on each accept.
REQ-020 SHALL move ACC->HOLD on the clock of the FRAME_LEN-th accept; sum/sat/terms then show the final frame values while out_valid=1.
REQ-021 SHALL, when flush=1 in ACC with count>0, move to HOLD next edge; an accept on the same cycle is included in the frame.
REQ-022 SHALL ignore flush in ACC when count==0 and no accept occurs that cycle.
REQ-023 SHALL ignore flush in HOLD.
REQ-024 SHALL, on out_valid && out_ready in HOLD, move HOLD->ACC, clearing acc, count and sat; no input is accepted in that cycle (no bypass).
REQ-025 SHALL hold sum/sat/terms stable throughout HOLD until the handshake.
REQ-026 SHALL keep sum/sat/terms at their last values in ACC; they are don't-care to downstream while out_valid=0.
REQ-027 SHALL have a latency of one clock from the final accept (or flush) to out_valid=1.
REQ-028 SHALL sustain a throughput of FRAME_LEN+1 cycles per frame minimum with out_ready tied high.
REQ-029 SHALL leave product ignored when in_valid=0, and in_valid ignored in HOLD.

Reset
REQ-030 SHALL, while rst=1, immediately force state=ACC, acc=0, count=0, sat=0, sum=0, terms=0, in_ready=1, out_valid=0.
REQ-031 SHALL discard any partial frame or held result on reset mid-operation; the first edge after rst deasserts behaves as a fresh frame start.

Verification
REQ-032 SHALL cover, with defaults and out_ready=1: products 10, -3, 25, -32 on consecutive cycles -> next cycle out_valid=1, sum=0, terms=4, sat=0; out_valid held one cycle; in_ready=0 that cycle.
REQ-033 SHALL cover backpressure: out_ready=0 for 5 cycles after frame end -> out_valid and sum stay fixed, in_ready=0, in_valid products not consumed; handshake then returns to ACC.
REQ-034 SHALL cover flush: products 7, 8, then flush alone -> sum=15, terms=2; flush with count=0 -> no output.
REQ-035 SHALL cover flush on the same cycle as the 2nd accept: products 100, 200 -> sum=300, terms=2.
REQ-036 SHALL cover saturation with ACC_WIDTH=12: products 1024 x4 -> sum=2047, sat=1; next frame -1024 x4 -> sum=-2048, sat=1; next frame 1, 1 flushed -> sat=0.
REQ-037 SHALL cover reset after 3 accepts -> outputs at reset values immediately; the following 4 products 1, 1, 1, 1 -> sum=4, terms=4.
